// File: rtl/usb1d_pkg.sv
// Shared definitions for the USB1 device receive path: disassembler FSM states,
// PID codes, CRC constants and small bit-order helpers.
package usb1d_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_TOKEN    = 4'b0010,
    ST_DATA     = 4'b0100,
    ST_WAIT_END = 4'b1000
  } dasm_state_e;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NACK  = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic logic is_token_pid(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) ||
           (p == PID_SETUP) || (p == PID_PING);
  endfunction

  function automatic logic is_data_pid(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
  endfunction

  function automatic logic is_hs_pid(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NACK) || (p == PID_STALL) || (p == PID_NYET);
  endfunction

  // The CRC engines consume their MSB first; USB sends bytes LSB first.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  function automatic logic [10:0] rev11(input logic [10:0] v);
    logic [10:0] r;
    for (int i = 0; i < 11; i++) r[i] = v[10-i];
    return r;
  endfunction

endpackage

// File: rtl/usb1d_crc16.sv
// USB data CRC16 (x^16+x^15+x^2+1), one byte per call; din[7] is the first bit on the wire.
module usb1d_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  din,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ din[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb1d_crc5.sv
// USB token CRC5 (x^5+x^2+1) over 11 bits; din[10] is the first bit on the wire.
module usb1d_crc5 (
  input  logic [4:0]  crc_in,
  input  logic [10:0] din,
  output logic [4:0]  crc_out
);

  always_comb begin
    logic [4:0] c;
    c = crc_in;
    for (int i = 10; i >= 0; i--) begin
      if (c[4] ^ din[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else               c = {c[3:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb1d_pkt_dasm.sv
// USB1 device packet disassembler: checks/latches the PID, decodes tokens with CRC5,
// forwards data payload with the CRC16 bytes stripped, and flags sequence/abort errors.
module usb1d_pkt_dasm
  import usb1d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_err,
  output logic [3:0]  pid,
  output logic        pid_valid,
  output logic        pid_cks_err,
  output logic        token_valid,
  output logic [6:0]  token_fadr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_no,
  output logic        crc5_err,
  output logic        hs_valid,
  output logic [7:0]  rx_data_st,
  output logic        rx_data_valid,
  output logic        rx_data_done,
  output logic        crc16_err,
  output logic        seq_err,
  output logic        rx_abort,
  output logic [3:0]  state
);

  dasm_state_e state_q, state_d;
  logic        rx_active_q, armed_q, armed_d, aborted_q, aborted_d, hs_q, hs_d;
  logic [1:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  tok0_q, tok0_d, tok1_q, tok1_d;
  logic [7:0]  pipe0_q, pipe0_d, pipe1_q, pipe1_d;
  logic [15:0] crc16_q, crc16_d, crc16_next;
  logic [4:0]  crc5_calc;
  logic [10:0] tok_field;
  logic        rx_acc, abort_cond;

  logic [3:0]  pid_q, pid_d;
  logic        pid_valid_q, pid_valid_d, pid_cks_err_q, pid_cks_err_d;
  logic        token_valid_q, token_valid_d, crc5_err_q, crc5_err_d;
  logic [6:0]  token_fadr_q, token_fadr_d;
  logic [3:0]  token_endp_q, token_endp_d;
  logic [10:0] frame_no_q, frame_no_d;
  logic        hs_valid_q, hs_valid_d;
  logic [7:0]  rx_data_st_q, rx_data_st_d;
  logic        rx_data_valid_q, rx_data_valid_d, rx_data_done_q, rx_data_done_d;
  logic        crc16_err_q, crc16_err_d, seq_err_q, seq_err_d, rx_abort_q, rx_abort_d;

  assign tok_field = {tok1_q[2:0], tok0_q};

  usb1d_crc5 u_crc5 (
    .crc_in  (CRC5_INIT),
    .din     (rev11(tok_field)),
    .crc_out (crc5_calc)
  );

  usb1d_crc16 u_crc16 (
    .crc_in  (crc16_q),
    .din     (rev8(rx_data)),
    .crc_out (crc16_next)
  );

  // armed_q blocks PID decoding after reset until the bus has been idle once,
  // so the tail of a packet cut by reset is never mistaken for a new PID.
  always_comb begin
    rx_acc     = rx_active & rx_valid;
    abort_cond = rx_err & (rx_active | rx_active_q) & ~aborted_q;
    cnt_inc    = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;

    state_d         = state_q;
    armed_d         = armed_q | ~rx_active;
    aborted_d       = aborted_q;
    hs_d            = hs_q;
    cnt_d           = cnt_q;
    tok0_d          = tok0_q;
    tok1_d          = tok1_q;
    pipe0_d         = pipe0_q;
    pipe1_d         = pipe1_q;
    crc16_d         = crc16_q;
    pid_d           = pid_q;
    token_fadr_d    = token_fadr_q;
    token_endp_d    = token_endp_q;
    frame_no_d      = frame_no_q;
    rx_data_st_d    = rx_data_st_q;
    pid_valid_d     = 1'b0;
    pid_cks_err_d   = 1'b0;
    token_valid_d   = 1'b0;
    crc5_err_d      = 1'b0;
    hs_valid_d      = 1'b0;
    rx_data_valid_d = 1'b0;
    rx_data_done_d  = 1'b0;
    crc16_err_d     = 1'b0;
    seq_err_d       = 1'b0;
    rx_abort_d      = 1'b0;

    if (state_q != ST_IDLE && abort_cond) begin
      rx_abort_d = 1'b1;
      aborted_d  = 1'b1;
      hs_d       = 1'b0;
      cnt_d      = 2'd0;
      pipe0_d    = 8'd0;
      pipe1_d    = 8'd0;
      state_d    = ST_WAIT_END;
    end else begin
      case (state_q)
        ST_IDLE: begin
          aborted_d = 1'b0;
          if (rx_acc && armed_q) begin
            cnt_d = 2'd0;
            hs_d  = 1'b0;
            if (rx_data[3:0] != ~rx_data[7:4]) begin
              pid_cks_err_d = 1'b1;
              state_d       = ST_WAIT_END;
            end else begin
              pid_d       = rx_data[3:0];
              pid_valid_d = 1'b1;
              if (is_token_pid(rx_data[3:0])) begin
                state_d = ST_TOKEN;
              end else if (is_data_pid(rx_data[3:0])) begin
                crc16_d = CRC16_INIT;
                state_d = ST_DATA;
              end else if (is_hs_pid(rx_data[3:0])) begin
                hs_d    = 1'b1;
                state_d = ST_WAIT_END;
              end else begin
                state_d = ST_WAIT_END;
              end
            end
          end
        end

        ST_TOKEN: begin
          if (!rx_active) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            if (cnt_q == 2'd2) begin
              token_valid_d = 1'b1;
              crc5_err_d    = (tok1_q[7:3] != rev5(~crc5_calc));
              if (pid_q == PID_SOF) begin
                frame_no_d = tok_field;
              end else begin
                token_fadr_d = tok0_q[6:0];
                token_endp_d = {tok1_q[2:0], tok0_q[7]};
              end
            end else begin
              seq_err_d = 1'b1;
            end
          end else if (rx_acc) begin
            if (cnt_q == 2'd0) tok0_d = rx_data;
            if (cnt_q == 2'd1) tok1_d = rx_data;
            cnt_d = cnt_inc;
          end
        end

        // The last two bytes held in the pipe at EOP are the CRC16 and are dropped.
        ST_DATA: begin
          if (!rx_active) begin
            state_d        = ST_IDLE;
            rx_data_done_d = 1'b1;
            crc16_err_d    = (crc16_q != CRC16_RESIDUAL) || (cnt_q < 2'd2);
            cnt_d          = 2'd0;
            pipe0_d        = 8'd0;
            pipe1_d        = 8'd0;
          end else if (rx_acc) begin
            crc16_d = crc16_next;
            cnt_d   = cnt_inc;
            case (cnt_q)
              2'd0:    pipe0_d = rx_data;
              2'd1:    pipe1_d = rx_data;
              default: begin
                rx_data_st_d    = pipe0_q;
                rx_data_valid_d = 1'b1;
                pipe0_d         = pipe1_q;
                pipe1_d         = rx_data;
              end
            endcase
          end
        end

        ST_WAIT_END: begin
          if (!rx_active) begin
            state_d = ST_IDLE;
            hs_d    = 1'b0;
            cnt_d   = 2'd0;
            if (hs_q) begin
              if (cnt_q == 2'd0) hs_valid_d = 1'b1;
              else               seq_err_d  = 1'b1;
            end
          end else if (rx_acc) begin
            cnt_d = cnt_inc;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rx_active_q     <= 1'b0;
      armed_q         <= 1'b0;
      aborted_q       <= 1'b0;
      hs_q            <= 1'b0;
      cnt_q           <= 2'd0;
      tok0_q          <= 8'd0;
      tok1_q          <= 8'd0;
      pipe0_q         <= 8'd0;
      pipe1_q         <= 8'd0;
      crc16_q         <= 16'd0;
      pid_q           <= 4'd0;
      pid_valid_q     <= 1'b0;
      pid_cks_err_q   <= 1'b0;
      token_valid_q   <= 1'b0;
      crc5_err_q      <= 1'b0;
      token_fadr_q    <= 7'd0;
      token_endp_q    <= 4'd0;
      frame_no_q      <= 11'd0;
      hs_valid_q      <= 1'b0;
      rx_data_st_q    <= 8'd0;
      rx_data_valid_q <= 1'b0;
      rx_data_done_q  <= 1'b0;
      crc16_err_q     <= 1'b0;
      seq_err_q       <= 1'b0;
      rx_abort_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_active_q     <= rx_active;
      armed_q         <= armed_d;
      aborted_q       <= aborted_d;
      hs_q            <= hs_d;
      cnt_q           <= cnt_d;
      tok0_q          <= tok0_d;
      tok1_q          <= tok1_d;
      pipe0_q         <= pipe0_d;
      pipe1_q         <= pipe1_d;
      crc16_q         <= crc16_d;
      pid_q           <= pid_d;
      pid_valid_q     <= pid_valid_d;
      pid_cks_err_q   <= pid_cks_err_d;
      token_valid_q   <= token_valid_d;
      crc5_err_q      <= crc5_err_d;
      token_fadr_q    <= token_fadr_d;
      token_endp_q    <= token_endp_d;
      frame_no_q      <= frame_no_d;
      hs_valid_q      <= hs_valid_d;
      rx_data_st_q    <= rx_data_st_d;
      rx_data_valid_q <= rx_data_valid_d;
      rx_data_done_q  <= rx_data_done_d;
      crc16_err_q     <= crc16_err_d;
      seq_err_q       <= seq_err_d;
      rx_abort_q      <= rx_abort_d;
    end
  end

  assign pid           = pid_q;
  assign pid_valid     = pid_valid_q;
  assign pid_cks_err   = pid_cks_err_q;
  assign token_valid   = token_valid_q;
  assign token_fadr    = token_fadr_q;
  assign token_endp    = token_endp_q;
  assign frame_no      = frame_no_q;
  assign crc5_err      = crc5_err_q;
  assign hs_valid      = hs_valid_q;
  assign rx_data_st    = rx_data_st_q;
  assign rx_data_valid = rx_data_valid_q;
  assign rx_data_done  = rx_data_done_q;
  assign crc16_err     = crc16_err_q;
  assign seq_err       = seq_err_q;
  assign rx_abort      = rx_abort_q;
  assign state         = state_q;

endmodule
